sdes_round_engine: RTL and testbench

- Iterative S-DES encrypt/decrypt core that consumes the S0/S1 substitution lookups inside its round function.
- Accepts one 8-bit block plus a 10-bit key per transaction.
- Generates K1/K2 internally, then runs IP, fk, SW, fk and IP^-1 over registered cycles.
- Returns the 8-bit result with a one-cycle done pulse. It sits between the board I/O wrapper (switches/keys) and the display/result logic.

---
 rtl/sdes_pkg.sv | 51 +++++
 rtl/sdes_round_engine_if.sv | 22 ++
 rtl/sdes_fk.sv | 22 ++
 rtl/sdes_round_engine.sv | 132 +++++++++++++
 tb/tb_sdes_round_engine.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: engine state encoding, S-box tables and the fixed
// bit permutations used by the key schedule and the round function.
package sdes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEYS = 2'd1,
        R1   = 2'd2,
        R2   = 2'd3
    } state_e;

    // Indexed directly by the raw nibble; row {b1,b4} / col {b2,b3} already folded in.
    localparam logic [15:0][1:0] S0_TABLE = {
        2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0,
        2'd0, 2'd2, 2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1
    };
    localparam logic [15:0][1:0] S1_TABLE = {
        2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3,
        2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0
    };

    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] d);
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] d);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    // Only shifts of one and two are ever needed by the key schedule.
    function automatic logic [4:0] rotl5(input logic [4:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[2:0], x[4:3]} : {x[3:0], x[4]};
    endfunction

endpackage

// File: rtl/sdes_round_engine_if.sv
// Request/result bundle between the board I/O wrapper and the S-DES engine.
interface sdes_round_engine_if;

    logic       i_start;
    logic       i_decrypt;
    logic [9:0] i_key;
    logic [7:0] i_data;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_data;

    modport master (
        output i_start, i_decrypt, i_key, i_data,
        input  o_busy, o_done, o_data
    );

    modport slave (
        input  i_start, i_decrypt, i_key, i_data,
        output o_busy, o_done, o_data
    );

endinterface

// File: rtl/sdes_fk.sv
// Combinational S-DES round function: newL = L ^ P4(S0,S1(E/P(R) ^ K)).
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [3:0] l_i,
    input  logic [3:0] r_i,
    input  logic [7:0] k_i,
    output logic [3:0] newL_o
);

    logic [7:0] mixed;
    logic [1:0] s0Out;
    logic [1:0] s1Out;

    always_comb begin
        mixed  = ep(r_i) ^ k_i;
        s0Out  = S0_TABLE[mixed[7:4]];
        s1Out  = S1_TABLE[mixed[3:0]];
        newL_o = l_i ^ p4({s0Out, s1Out});
    end

endmodule

// File: rtl/sdes_round_engine.sv
// Iterative S-DES core: captures key/block, derives subkeys, runs two fk rounds
// and raises a one-cycle done pulse with the result three edges after accept.
module sdes_round_engine
    import sdes_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    sdes_round_engine_if.slave        bus
);

    state_e     state_q, state_d;
    logic [9:0] key_q, key_d;
    logic [7:0] data_q, data_d;
    logic       decrypt_q, decrypt_d;
    logic [7:0] ka_q, ka_d;
    logic [7:0] kb_q, kb_d;
    logic [3:0] l_q, l_d;
    logic [3:0] r_q, r_d;
    logic [7:0] result_q, result_d;
    logic       done_q, done_d;

    logic [9:0] keyP10;
    logic [4:0] left1;
    logic [4:0] right1;
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] fkKey;
    logic [3:0] newL;

    always_comb begin
        keyP10 = p10(key_q);
        left1  = rotl5(keyP10[9:5], 2'd1);
        right1 = rotl5(keyP10[4:0], 2'd1);
        k1     = p8({left1, right1});
        k2     = p8({rotl5(left1, 2'd2), rotl5(right1, 2'd2)});
    end

    // Subkeys are stored in use order, so round A always takes ka and round B kb.
    assign fkKey = (state_q == R2) ? kb_q : ka_q;

    sdes_fk uFk (
        .l_i    (l_q),
        .r_i    (r_q),
        .k_i    (fkKey),
        .newL_o (newL)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_start) state_d = KEYS;
            KEYS:    state_d = R1;
            R1:      state_d = R2;
            R2:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_d     = key_q;
        data_d    = data_q;
        decrypt_d = decrypt_q;
        ka_d      = ka_q;
        kb_d      = kb_q;
        l_d       = l_q;
        r_d       = r_q;
        result_d  = result_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    key_d     = bus.i_key;
                    data_d    = bus.i_data;
                    decrypt_d = bus.i_decrypt;
                end
            end
            KEYS: begin
                ka_d       = decrypt_q ? k2 : k1;
                kb_d       = decrypt_q ? k1 : k2;
                {l_d, r_d} = ip(data_q);
            end
            R1: begin
                l_d = r_q;
                r_d = newL;
            end
            R2: begin
                result_d = ip_inv({newL, r_q});
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            key_q     <= '0;
            data_q    <= '0;
            decrypt_q <= 1'b0;
            ka_q      <= '0;
            kb_q      <= '0;
            l_q       <= '0;
            r_q       <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            key_q     <= key_d;
            data_q    <= data_d;
            decrypt_q <= decrypt_d;
            ka_q      <= ka_d;
            kb_q      <= kb_d;
            l_q       <= l_d;
            r_q       <= r_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        bus.o_busy = (state_q != IDLE);
        bus.o_done = done_q;
        bus.o_data = result_q;
    end

endmodule

// File: tb/tb_sdes_round_engine.sv
// Self-checking bench for sdes_round_engine against a table-driven S-DES model.
module tb_sdes_round_engine;

    logic i_clk = 1'b0;
    logic i_rst;

    sdes_round_engine_if bus ();

    sdes_round_engine dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;

    int P10_T[$] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int P8_T[$]  = '{6, 3, 7, 4, 8, 5, 10, 9};
    int IP_T[$]  = '{2, 6, 3, 1, 4, 8, 5, 7};
    int IPI_T[$] = '{4, 1, 3, 5, 7, 2, 8, 6};
    int EP_T[$]  = '{4, 1, 2, 3, 2, 3, 4, 1};
    int P4_T[$]  = '{2, 4, 3, 1};
    int S0_M[4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int S1_M[4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    // Generic position-list permutation: output bit i takes input position tbl[i] (1 = MSB).
    function automatic logic [15:0] permute(input logic [15:0] v, input int inW, input int tbl[$]);
        logic [15:0] res;
        res = '0;
        foreach (tbl[i]) res = {res[14:0], v[inW - tbl[i]]};
        return res;
    endfunction

    function automatic logic [1:0] sboxLookup(input int box, input logic [3:0] n);
        int row;
        int col;
        row = {n[3], n[0]};
        col = {n[2], n[1]};
        return (box == 0) ? 2'(S0_M[row][col]) : 2'(S1_M[row][col]);
    endfunction

    function automatic logic [4:0] rotModel(input logic [4:0] x, input int n);
        return 5'(((int'(x) << n) | (int'(x) >> (5 - n))) & 31);
    endfunction

    function automatic logic [3:0] modelF(input logic [3:0] r, input logic [7:0] k);
        logic [7:0] x;
        logic [3:0] s;
        x = 8'(permute({12'b0, r}, 4, EP_T)) ^ k;
        s = {sboxLookup(0, x[7:4]), sboxLookup(1, x[3:0])};
        return 4'(permute({12'b0, s}, 4, P4_T));
    endfunction

    function automatic logic [7:0] modelCipher(input logic [9:0] key, input logic [7:0] data, input logic dec);
        logic [9:0] p;
        logic [4:0] lh;
        logic [4:0] rh;
        logic [7:0] k1;
        logic [7:0] k2;
        logic [7:0] t;
        logic [3:0] lw;
        logic [3:0] rw;
        logic [3:0] tmp;
        p  = 10'(permute({6'b0, key}, 10, P10_T));
        lh = rotModel(p[9:5], 1);
        rh = rotModel(p[4:0], 1);
        k1 = 8'(permute({6'b0, lh, rh}, 10, P8_T));
        lh = rotModel(lh, 2);
        rh = rotModel(rh, 2);
        k2 = 8'(permute({6'b0, lh, rh}, 10, P8_T));
        t  = 8'(permute({8'b0, data}, 8, IP_T));
        lw = t[7:4];
        rw = t[3:0];
        lw = lw ^ modelF(rw, dec ? k2 : k1);
        tmp = lw;
        lw = rw;
        rw = tmp;
        lw = lw ^ modelF(rw, dec ? k1 : k2);
        return 8'(permute({8'b0, lw, rw}, 8, IPI_T));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one transaction; scrambles inputs after accept to prove they are captured.
    task automatic applyStimulus(input logic dec, input logic [9:0] key, input logic [7:0] data,
                                 output logic [7:0] result, output int latency, output logic busySeen);
        bus.i_decrypt = dec;
        bus.i_key     = key;
        bus.i_data    = data;
        bus.i_start   = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_start   = 1'b0;
        bus.i_key     = 10'($urandom);
        bus.i_data    = 8'($urandom);
        bus.i_decrypt = 1'($urandom);
        busySeen      = bus.o_busy;
        latency       = 0;
        while (bus.o_done !== 1'b1 && latency < 12) begin
            @(posedge i_clk);
            #1;
            latency++;
        end
        result = bus.o_data;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] key;
        logic [7:0] data;
        logic [7:0] res;
        logic [7:0] res2;
        logic       busySeen;
        int         lat;
        logic [7:0] heldData[12];
        int         doneCycles[$];
        logic [7:0] doneData[$];
        int         anyDone;

        bus.i_start   = 1'b0;
        bus.i_decrypt = 1'b0;
        bus.i_key     = '0;
        bus.i_data    = '0;

        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("reset_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("reset_done", 32'(bus.o_done), 32'd0);
        checkOutput("reset_data", 32'(bus.o_data), 32'h00);
        i_rst = 1'b0;

        key = 10'b1010000010;
        applyStimulus(1'b0, key, 8'b10010111, res, lat, busySeen);
        checkOutput("enc_busy_after_accept", 32'(busySeen), 32'd1);
        checkOutput("enc_latency", 32'(lat), 32'd3);
        checkOutput("enc_data", 32'(res), 32'(8'b00111000));
        checkOutput("enc_busy_at_done", 32'(bus.o_busy), 32'd0);
        checkOutput("enc_k1", 32'(dut.ka_q), 32'(8'b10100100));
        checkOutput("enc_k2", 32'(dut.kb_q), 32'(8'b01000011));
        @(posedge i_clk);
        #1;
        checkOutput("enc_done_width", 32'(bus.o_done), 32'd0);
        checkOutput("enc_data_hold", 32'(bus.o_data), 32'(8'b00111000));

        applyStimulus(1'b1, key, 8'b00111000, res, lat, busySeen);
        checkOutput("dec_latency", 32'(lat), 32'd3);
        checkOutput("dec_data", 32'(res), 32'(8'b10010111));
        checkOutput("dec_ka_is_k2", 32'(dut.ka_q), 32'(8'b01000011));

        bus.i_key     = key;
        bus.i_decrypt = 1'b0;
        for (int k = 0; k < 12; k++) begin
            heldData[k] = 8'($urandom);
            bus.i_start = (k < 6);
            bus.i_data  = heldData[k];
            @(posedge i_clk);
            #1;
            if (bus.o_done === 1'b1) begin
                doneCycles.push_back(k);
                doneData.push_back(bus.o_data);
            end
        end
        bus.i_start = 1'b0;
        checkOutput("held_done_count", 32'(doneCycles.size()), 32'd2);
        checkOutput("held_first_cycle", 32'(doneCycles.size() > 0 ? doneCycles[0] : -1), 32'd3);
        checkOutput("held_second_cycle", 32'(doneCycles.size() > 1 ? doneCycles[1] : -1), 32'd7);
        checkOutput("held_first_data", 32'(doneData.size() > 0 ? doneData[0] : 8'hxx),
                    32'(modelCipher(key, heldData[0], 1'b0)));
        checkOutput("held_second_data", 32'(doneData.size() > 1 ? doneData[1] : 8'hxx),
                    32'(modelCipher(key, heldData[4], 1'b0)));
        checkOutput("held_data_hold", 32'(bus.o_data), 32'(modelCipher(key, heldData[4], 1'b0)));

        key  = 10'($urandom);
        data = 8'($urandom);
        bus.i_key     = key;
        bus.i_data    = data;
        bus.i_decrypt = 1'b0;
        bus.i_start   = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_start = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("abort_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("abort_done", 32'(bus.o_done), 32'd0);
        i_rst = 1'b0;
        anyDone = 0;
        repeat (5) begin
            @(posedge i_clk);
            #1;
            if (bus.o_done !== 1'b0) anyDone++;
        end
        checkOutput("abort_no_done", 32'(anyDone), 32'd0);
        checkOutput("abort_data_cleared", 32'(bus.o_data), 32'h00);
        applyStimulus(1'b0, key, data, res, lat, busySeen);
        checkOutput("after_abort_latency", 32'(lat), 32'd3);
        checkOutput("after_abort_data", 32'(res), 32'(modelCipher(key, data, 1'b0)));

        for (int it = 0; it < 200; it++) begin
            key  = 10'($urandom);
            data = 8'($urandom);
            applyStimulus(1'b0, key, data, res, lat, busySeen);
            checkOutput("rnd_enc_latency", 32'(lat), 32'd3);
            checkOutput("rnd_enc_data", 32'(res), 32'(modelCipher(key, data, 1'b0)));
            applyStimulus(1'b1, key, res, res2, lat, busySeen);
            checkOutput("rnd_roundtrip", 32'(res2), 32'(data));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
